// File: rtl/branch_target_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer_if
// Description : BTB port bundle, one combinational read port and one write port.
// Revision    : 1.0
// ============================================================================
interface branch_target_buffer_if #(
    parameter int IDX_W = 3
);
    // Frame layout, MSB first: {valid, tag, target[31:0], state[1:0]}
    localparam int c_tag_w   = 30 - IDX_W;
    localparam int c_frame_w = 1 + c_tag_w + 32 + 2;

    logic [IDX_W-1:0]     rsel;
    logic [IDX_W-1:0]     wsel;
    logic                 wen;
    logic [c_frame_w-1:0] wdat;
    logic [c_frame_w-1:0] rdat;

    modport tb  (output rsel, wsel, wen, wdat, input rdat);
    modport mem (input rsel, wsel, wen, wdat, output rdat);
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Combinational BTB lookup for fetch plus a queued 2-bit counter updater.
// Revision    : 1.0
// ============================================================================
module branch_predict_unit #(
    parameter int IDX_W = 3
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    input  wire logic          fetch_valid,
    input  wire logic [31:0]   fetch_pc,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    input  wire logic          upd_valid,
    output logic               upd_ready,
    input  wire logic [31:0]   upd_pc,
    input  wire logic          upd_taken,
    input  wire logic [31:0]   upd_target,
    branch_target_buffer_if.tb bpif
);

    localparam int c_tag_w = 30 - IDX_W;

    typedef struct packed {
        logic               valid;
        logic [c_tag_w-1:0] tag;
        logic [31:0]        target;
        logic [1:0]         state;
    } frame_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [c_tag_w-1:0] tag_of(input logic [31:0] pc);
        return pc[31:IDX_W+2];
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] s);
        return (s == 2'b11) ? s : s + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] s);
        return (s == 2'b00) ? s : s - 2'd1;
    endfunction

    frame_t w_rd_frame;
    logic   w_fetch_hit;

    assign w_rd_frame  = bpif.rdat;
    assign w_fetch_hit = w_rd_frame.valid && (w_rd_frame.tag == tag_of(fetch_pc));
    assign pred_taken  = fetch_valid && w_fetch_hit && w_rd_frame.state[1];
    assign pred_target = pred_taken ? w_rd_frame.target : fetch_pc + 32'd4;

    // Two-entry update queue
    upd_t       r_fifo [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;
    upd_t       w_head;

    assign upd_ready = (r_count != 2'd2);
    assign w_push    = upd_valid && upd_ready;
    assign w_head    = r_fifo[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{pc: upd_pc, taken: upd_taken, target: upd_target};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Updater FSM
    state_t r_state;
    state_t w_next;
    frame_t r_frame;
    logic   w_latch;
    logic   w_head_hit;
    logic   w_lat_hit;
    frame_t w_wr_frame;

    assign w_head_hit = w_rd_frame.valid && (w_rd_frame.tag == tag_of(w_head.pc));
    assign w_lat_hit  = r_frame.valid && (r_frame.tag == tag_of(w_head.pc));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_frame <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_frame <= w_rd_frame;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_latch   = 1'b0;
        bpif.wen  = 1'b0;
        bpif.rsel = idx_of(fetch_pc);
        case (r_state)
            IDLE: begin
                if (r_count != 2'd0) w_next = RD;
            end
            RD: begin
                // Fetch owns the read port; the updater waits for an idle fetch cycle.
                if (!fetch_valid) begin
                    bpif.rsel = idx_of(w_head.pc);
                    w_latch   = 1'b1;
                    if (w_head_hit || w_head.taken) begin
                        w_next = WR;
                    end else begin
                        w_pop  = 1'b1;
                        w_next = IDLE;
                    end
                end
            end
            WR: begin
                bpif.wen = 1'b1;
                w_pop    = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_wr_frame = r_frame;
        if (w_lat_hit) begin
            if (w_head.taken) begin
                w_wr_frame.state  = sat_inc(r_frame.state);
                w_wr_frame.target = w_head.target;
            end else begin
                w_wr_frame.state  = sat_dec(r_frame.state);
            end
        end else begin
            w_wr_frame.valid  = 1'b1;
            w_wr_frame.tag    = tag_of(w_head.pc);
            w_wr_frame.target = w_head.target;
            w_wr_frame.state  = 2'b10;
        end
    end

    assign bpif.wsel = idx_of(w_head.pc);
    assign bpif.wdat = w_wr_frame;

    logic w_unused;
    assign w_unused = ^w_head.pc[1:0];

endmodule
`default_nettype wire
